// File: rtl/count_display_pkg.sv
// -----------------------------------------------------------------------------
// count_display_pkg
// Shared definitions for the count/display sequencer: FSM state encodings,
// digit count, the seven-segment code table and the blank code.
// Segment codes are {g,f,e,d,c,b,a}, active-low.
// -----------------------------------------------------------------------------
package count_display_pkg;

   localparam int NUM_DIGITS = 4;

   typedef logic [3:0] bcd_digit_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic logic [6:0] seg_encode(input bcd_digit_t digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = 7'h40;
         4'd1:    seg = 7'h79;
         4'd2:    seg = 7'h24;
         4'd3:    seg = 7'h30;
         4'd4:    seg = 7'h19;
         4'd5:    seg = 7'h12;
         4'd6:    seg = 7'h02;
         4'd7:    seg = 7'h78;
         4'd8:    seg = 7'h00;
         4'd9:    seg = 7'h10;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// -----------------------------------------------------------------------------
// bcd_digit_step
// One decade of the cascaded BCD counter, purely combinational.
//   digit      in  4  current BCD digit (0..9)
//   en         in  1  step this digit (tick for digit 0, carry/borrow otherwise)
//   down       in  1  0 = increment, 1 = decrement
//   next_digit out 4  digit value after the step
//   carry_out  out 1  carry (up, 9->0) or borrow (down, 0->9) into next digit
// -----------------------------------------------------------------------------
module bcd_digit_step
   import count_display_pkg::*;
(
   input  bcd_digit_t digit,
   input  logic       en,
   input  logic       down,
   output bcd_digit_t next_digit,
   output logic       carry_out
);

   always_comb begin
      next_digit = digit;
      carry_out  = 1'b0;
      if (en) begin
         if (down) begin
            carry_out  = (digit == 4'd0);
            next_digit = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
         end else begin
            // >= keeps the digit inside 0..9 even from an illegal value
            carry_out  = (digit >= 4'd9);
            next_digit = (digit >= 4'd9) ? 4'd0 : digit + 4'd1;
         end
      end
   end

endmodule

// File: rtl/count_display_ctrl.sv
// -----------------------------------------------------------------------------
// count_display_ctrl
// Sequencer for a 4-digit BCD up/down counter on a multiplexed 7-seg display.
//   clock_100Mhz   in   1   system clock
//   reset          in   1   asynchronous, active-high
//   btn_start_stop in   1   debounced button, asynchronous (IDLE/PAUSE->RUN, RUN->PAUSE)
//   btn_clear      in   1   debounced button, asynchronous (any state -> IDLE, zero)
//   count_down     in   1   level, asynchronous; 1 = count down
//   anode          out  4   digit enables, active-low
//   cathode        out  7   {g,f,e,d,c,b,a}, active-low
//   dp             out  1   decimal point, active-low (lit on digit 0 while paused)
//   running        out  1   state == RUN
//   wrap_pulse     out  1   one-cycle pulse after a 9999<->0000 wrap
//   count_bcd      out  16  {d3,d2,d1,d0}
// -----------------------------------------------------------------------------
module count_display_ctrl
   import count_display_pkg::*;
#(
   parameter int COUNT_DIV   = 100_000_000,
   parameter int REFRESH_DIV = 100_000,
   parameter int BLANK_LZ    = 1
) (
   input  logic        clock_100Mhz,
   input  logic        reset,
   input  logic        btn_start_stop,
   input  logic        btn_clear,
   input  logic        count_down,
   output logic [3:0]  anode,
   output logic [6:0]  cathode,
   output logic        dp,
   output logic        running,
   output logic        wrap_pulse,
   output logic [15:0] count_bcd
);

   localparam int CW = $clog2(COUNT_DIV);
   localparam int RW = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] COUNT_MAX   = CW'(COUNT_DIV - 1);
   localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);

   // bit 0 = start_stop, bit 1 = clear, bit 2 = count_down
   logic [2:0]  sync1_q, sync1_d, sync2_q, sync2_d;
   logic [1:0]  btn_prev_q, btn_prev_d;
   logic [1:0]  state_q, state_d;
   logic [CW-1:0] presc_q, presc_d;
   logic [RW-1:0] refresh_q, refresh_d;
   logic [1:0]  scan_idx_q, scan_idx_d;
   logic [15:0] count_q, count_d;
   logic [3:0]  anode_q, anode_d;
   logic [6:0]  cathode_q, cathode_d;
   logic        dp_q, dp_d;
   logic        running_q, running_d;
   logic        wrap_q, wrap_d;

   logic        start_pulse, clear_pulse, dir_down, tick;
   logic [15:0] count_next;
   logic [NUM_DIGITS:0]   carry;
   logic [NUM_DIGITS-1:0] upper_zero;
   logic [3:0]  scan_digit;
   logic        scan_blank;

   assign start_pulse = sync2_q[0] & ~btn_prev_q[0];
   assign clear_pulse = sync2_q[1] & ~btn_prev_q[1];
   assign dir_down    = sync2_q[2];
   assign tick        = (state_q == ST_RUN) && (presc_q == COUNT_MAX);

   // Ripple chain: digit 0 steps on tick, each higher digit on the carry below.
   assign carry[0] = tick;
   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         bcd_digit_step u_step (
            .digit      (count_q[4*gi +: 4]),
            .en         (carry[gi]),
            .down       (dir_down),
            .next_digit (count_next[4*gi +: 4]),
            .carry_out  (carry[gi+1])
         );
         // digit gi and every digit above it are zero
         assign upper_zero[gi] = (count_q[4*NUM_DIGITS-1 : 4*gi] == '0);
      end
   endgenerate

   assign scan_digit = count_q[{scan_idx_q, 2'b00} +: 4];
   assign scan_blank = (BLANK_LZ != 0) && (scan_idx_q != 2'd0) && upper_zero[scan_idx_q];

   always_comb begin
      sync1_d    = {count_down, btn_clear, btn_start_stop};
      sync2_d    = sync1_q;
      btn_prev_d = sync2_q[1:0];

      state_d = state_q;
      presc_d = presc_q;
      count_d = count_q;
      wrap_d  = 1'b0;

      if (clear_pulse) begin
         // clear takes priority over a coincident start_stop pulse
         state_d = ST_IDLE;
         count_d = '0;
         presc_d = '0;
      end else begin
         count_d = count_next;
         wrap_d  = carry[NUM_DIGITS];
         case (state_q)
            ST_RUN: begin
               presc_d = tick ? '0 : presc_q + 1'b1;
               if (start_pulse) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
               if (start_pulse) state_d = ST_RUN;
            end
            default: begin
               presc_d = '0;
               if (start_pulse) state_d = ST_RUN;
            end
         endcase
      end
      running_d = (state_d == ST_RUN);

      refresh_d  = refresh_q + 1'b1;
      scan_idx_d = scan_idx_q;
      if (refresh_q == REFRESH_MAX) begin
         refresh_d  = '0;
         scan_idx_d = scan_idx_q + 2'd1;
      end

      anode_d   = ~(4'b0001 << scan_idx_q);
      cathode_d = scan_blank ? SEG_BLANK : seg_encode(scan_digit);
      dp_d      = ~((state_q == ST_PAUSE) && (scan_idx_q == 2'd0));
   end

   always_ff @(posedge clock_100Mhz or posedge reset) begin
      if (reset) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         btn_prev_q <= '0;
         state_q    <= ST_IDLE;
         presc_q    <= '0;
         refresh_q  <= '0;
         scan_idx_q <= '0;
         count_q    <= '0;
         anode_q    <= 4'b1111;
         cathode_q  <= SEG_BLANK;
         dp_q       <= 1'b1;
         running_q  <= 1'b0;
         wrap_q     <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         btn_prev_q <= btn_prev_d;
         state_q    <= state_d;
         presc_q    <= presc_d;
         refresh_q  <= refresh_d;
         scan_idx_q <= scan_idx_d;
         count_q    <= count_d;
         anode_q    <= anode_d;
         cathode_q  <= cathode_d;
         dp_q       <= dp_d;
         running_q  <= running_d;
         wrap_q     <= wrap_d;
      end
   end

   assign anode      = anode_q;
   assign cathode    = cathode_q;
   assign dp         = dp_q;
   assign running    = running_q;
   assign wrap_pulse = wrap_q;
   assign count_bcd  = count_q;

endmodule

// File: tb/tb_count_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_count_display_ctrl
// Random and directed stimulus against a decimal-integer reference model of
// the counter, FSM and display scan; every output is compared every cycle.
// -----------------------------------------------------------------------------
module tb_count_display_ctrl;

   localparam int CDIV = 4;
   localparam int RDIV = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        btn_ss, btn_cl, cnt_dn;
   logic [3:0]  anode;
   logic [6:0]  cathode;
   logic        dp, running, wrap_pulse;
   logic [15:0] count_bcd;

   count_display_ctrl #(.COUNT_DIV(CDIV), .REFRESH_DIV(RDIV), .BLANK_LZ(1)) dut (
      .clock_100Mhz   (clk),
      .reset          (reset),
      .btn_start_stop (btn_ss),
      .btn_clear      (btn_cl),
      .count_down     (cnt_dn),
      .anode          (anode),
      .cathode        (cathode),
      .dp             (dp),
      .running        (running),
      .wrap_pulse     (wrap_pulse),
      .count_bcd      (count_bcd)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   // reference model: 0 = idle, 1 = run, 2 = pause; count as a plain integer
   int   m_state, m_count, m_presc, m_n, m_wraps;
   bit   h_ss [3], h_cl [3], h_dn [3];
   logic [3:0] exp_anode;
   logic [6:0] exp_cathode;
   logic       exp_dp, exp_wrap;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   task automatic model_reset();
      m_state = 0; m_count = 0; m_presc = 0; m_n = 0;
      for (int k = 0; k < 3; k++) begin h_ss[k] = 0; h_cl[k] = 0; h_dn[k] = 0; end
      exp_anode = 4'b1111; exp_cathode = 7'h7F; exp_dp = 1'b1; exp_wrap = 1'b0;
   endtask

   task automatic model_edge();
      int idx, pw, dig;
      bit ss, cl, dn, tick;
      if (reset) begin model_reset(); return; end
      // display reflects scan position and state/count before this edge
      idx = (m_n / RDIV) % 4;
      pw  = 1;
      for (int k = 0; k < idx; k++) pw = pw * 10;
      dig = (m_count / pw) % 10;
      exp_anode      = 4'b1111;
      exp_anode[idx] = 1'b0;
      exp_cathode    = (idx > 0 && m_count < pw) ? 7'h7F : seg_tab[dig];
      exp_dp         = !(m_state == 2 && idx == 0);
      // button edges take effect 3 edges after the raw rise
      ss   = h_ss[1] & !h_ss[2];
      cl   = h_cl[1] & !h_cl[2];
      dn   = h_dn[1];
      tick = (m_state == 1) && (m_presc == CDIV - 1);
      exp_wrap = 1'b0;
      if (cl) begin
         m_state = 0; m_count = 0; m_presc = 0;
      end else begin
         if (tick) begin
            if (dn) begin
               exp_wrap = (m_count == 0);
               m_count  = (m_count + 9999) % 10000;
            end else begin
               exp_wrap = (m_count == 9999);
               m_count  = (m_count + 1) % 10000;
            end
            if (exp_wrap) m_wraps++;
         end
         if (m_state == 1)      m_presc = tick ? 0 : m_presc + 1;
         else if (m_state == 0) m_presc = 0;
         if (ss) m_state = (m_state == 1) ? 2 : 1;
      end
      h_ss[2] = h_ss[1]; h_ss[1] = h_ss[0]; h_ss[0] = btn_ss;
      h_cl[2] = h_cl[1]; h_cl[1] = h_cl[0]; h_cl[0] = btn_cl;
      h_dn[2] = h_dn[1]; h_dn[1] = h_dn[0]; h_dn[0] = cnt_dn;
      m_n++;
   endtask

   task automatic check_all();
      check_eq("count_bcd", count_bcd, to_bcd(m_count));
      check_eq("running", 16'(running), 16'(m_state == 1));
      check_eq("wrap_pulse", 16'(wrap_pulse), 16'(exp_wrap));
      check_eq("anode", 16'(anode), 16'(exp_anode));
      check_eq("cathode", 16'(cathode), 16'(exp_cathode));
      check_eq("dp", 16'(dp), 16'(exp_dp));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic press(input bit ss, input bit cl, input int hold);
      btn_ss = ss; btn_cl = cl;
      repeat (hold) cyc();
      btn_ss = 1'b0; btn_cl = 1'b0;
      repeat (3) cyc();
   endtask

   // asynchronous reset: outputs must drop before the next clock edge
   task automatic mid_reset();
      reset = 1'b1;
      model_reset();
      #1 check_all();
      repeat (3) cyc();
      reset = 1'b0;
   endtask

   initial begin
      int r;
      reset = 1'b1; btn_ss = 1'b0; btn_cl = 1'b0; cnt_dn = 1'b0;
      m_wraps = 0;
      model_reset();
      @(negedge clk);
      check_all();
      repeat (5) cyc();
      reset = 1'b0;
      repeat (12) cyc();

      press(1'b1, 1'b0, 2);
      repeat (30) cyc();
      // clear and start together while running: clear wins
      press(1'b1, 1'b1, 1);
      repeat (10) cyc();

      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 4)       press(1'b1, 1'b0, $urandom_range(1, 4));
         else if (r < 6)  press(1'b0, 1'b1, $urandom_range(1, 4));
         else if (r == 6) press(1'b1, 1'b1, 1);
         else if (r == 7) begin cnt_dn = 1'($urandom_range(0, 1)); cyc(); end
         else if (r == 8 && $urandom_range(0, 9) == 0) mid_reset();
         else cyc();
      end

      // count down from zero: 0000 -> 9999 -> 9998
      press(1'b0, 1'b1, 1);
      cnt_dn = 1'b1;
      repeat (4) cyc();
      press(1'b1, 1'b0, 1);
      repeat (24) cyc();
      press(1'b0, 1'b1, 1);

      // count up, pause at 0042, resume, then run through the 9999 wrap
      cnt_dn = 1'b0;
      repeat (4) cyc();
      press(1'b1, 1'b0, 1);
      for (int i = 0; i < 400 && m_count != 42; i++) cyc();
      check_eq("reach_42", to_bcd(m_count), 16'h0042);
      press(1'b1, 1'b0, 1);
      repeat (100) cyc();
      press(1'b1, 1'b0, 1);
      m_wraps = 0;
      for (int i = 0; i < 45000 && m_count != 9999; i++) cyc();
      repeat (12) cyc();
      check_eq("up_wrap_seen", 16'(m_wraps), 16'd1);

      mid_reset();
      repeat (6) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
